// File: rtl/btn_conditioner_pkg.sv
// Shared constants, channel state encoding and sizing helper for the button conditioner.
package btn_conditioner_pkg;

    localparam int BTN_SZ             = 3;
    localparam int DB_CYCLES_DEFAULT  = 1_000_000;
    localparam int REP_DELAY_DEFAULT  = 50_000_000;
    localparam int REP_PERIOD_DEFAULT = 20_000_000;
    localparam int CNT_W_DEFAULT      = 28;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } ch_state_t;

    function automatic longint unsigned max3(input longint unsigned a,
                                              input longint unsigned b,
                                              input longint unsigned c);
        longint unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM and, when BTN_AUTOREPEAT_EN is
// defined, an auto-repeat counter active while the button is held.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   IDLE      | released and stable
//   DEB_PRESS | sync high, counting stable cycles before accepting
//   HELD      | press accepted, level high
//   DEB_REL   | sync low, counting stable cycles before release
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int DB_CYCLES  = DB_CYCLES_DEFAULT,
    parameter int REP_DELAY  = REP_DELAY_DEFAULT,
    parameter int REP_PERIOD = REP_PERIOD_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o,
    output logic level_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    if (max3(DB_CYCLES, REP_DELAY, REP_PERIOD) >= (64'd1 << CNT_W)) begin : g_cnt_too_narrow
        $error("btn_debounce_ch: CNT_W too small for the configured cycle counts");
    end

    logic             meta;
    logic             sync;
    ch_state_t        state;
    ch_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             press_nx;
    logic             level_nx;
    logic             rep_fire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            press_o <= 1'b0;
            level_o <= 1'b0;
        end else begin
            meta    <= btn_i;
            sync    <= meta;
            state   <= state_nx;
            cnt     <= cnt_nx;
            press_o <= press_nx;
            level_o <= level_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        press_nx = 1'b0;
        level_nx = level_o;
        unique case (state)
            IDLE: begin
                if (sync) begin
                    state_nx = DEB_PRESS;
                    cnt_nx   = '0;
                end
            end
            DEB_PRESS: begin
                if (!sync) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                    level_nx = 1'b1;
                    press_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync) begin
                    state_nx = DEB_REL;
                    cnt_nx   = '0;
                end else begin
                    press_nx = rep_fire;
                end
            end
            DEB_REL: begin
                if (sync) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    level_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REP_PERIOD - 1);

    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_nx;
    logic             rep_first;
    logic             rep_first_nx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rcnt      <= '0;
            rep_first <= 1'b1;
        end else begin
            rcnt      <= rcnt_nx;
            rep_first <= rep_first_nx;
        end
    end

    // Anything other than a steady hold re-arms the long initial delay.
    always_comb begin
        rcnt_nx      = '0;
        rep_first_nx = 1'b1;
        rep_fire     = 1'b0;
        if (state == HELD && sync) begin
            rep_first_nx = rep_first;
            if (rcnt == (rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
                rep_fire     = 1'b1;
                rep_first_nx = 1'b0;
            end else begin
                rcnt_nx = rcnt + CNT_W'(1);
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Button front-end: one independent debounce channel per button, outputs concatenated.
// Define BTN_AUTOREPEAT_EN to build the auto-repeat logic in every channel.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int N_BTN      = BTN_SZ,
    parameter int DB_CYCLES  = DB_CYCLES_DEFAULT,
    parameter int REP_DELAY  = REP_DELAY_DEFAULT,
    parameter int REP_PERIOD = REP_PERIOD_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] level_o
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .CNT_W      (CNT_W),
            .DB_CYCLES  (DB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
        ) u_ch (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .btn_i   (btn_i[i]),
            .press_o (press_o[i]),
            .level_o (level_o[i])
        );
    end

endmodule
